// File: rtl/arb_mux_n_pkg.sv
// +----------------------------------------------------------------------+
// | arb_mux_n_pkg                                                        |
// | Shared arbitration-mode and lock-FSM encodings for arb_mux_n.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package arb_mux_n_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_mux_n_if.sv
// +----------------------------------------------------------------------+
// | arb_mux_n_if                                                         |
// | Request/response bundle for the N-channel arbitrating multiplexer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface arb_mux_n_if #(
  parameter int N_CH      = 4,
  parameter int BUS_WIDTH = 32
);

  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH-1:0]           i_valid;
  logic [N_CH*BUS_WIDTH-1:0] i_data;
  logic [N_CH-1:0]           i_lock;
  logic [N_CH-1:0]           o_ready;
  logic                      o_valid;
  logic [BUS_WIDTH-1:0]      o_data;
  logic [SEL_W-1:0]          o_sel;
  logic                      i_ready;

  modport slave (
    input  i_valid, i_data, i_lock, i_ready,
    output o_ready, o_valid, o_data, o_sel
  );

  modport master (
    output i_valid, i_data, i_lock, i_ready,
    input  o_ready, o_valid, o_data, o_sel
  );

endinterface

`default_nettype wire

// File: rtl/arb_mux_n_rr_pick.sv
// +----------------------------------------------------------------------+
// | arb_mux_n_rr_pick                                                    |
// | Rotating-priority encoder: first request at or above ptr, wrapping.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_mux_n_rr_pick #(
  parameter  int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_CH-1:0]  gnt_o,
  output logic [SEL_W-1:0] gnt_idx_o
);

  localparam logic [SEL_W:0] C_N = (SEL_W+1)'(N_CH);

  logic [SEL_W:0]   w_sum;
  logic [SEL_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_idx     = '0;
    for (int i = 0; i < N_CH; i++) begin
      // ptr + i modulo N_CH without a divider
      w_sum = {1'b0, ptr_i} + (SEL_W+1)'(i);
      if (w_sum >= C_N) begin
        w_sum = w_sum - C_N;
      end
      w_idx = w_sum[SEL_W-1:0];
      if (!w_found && req_i[w_idx]) begin
        w_found       = 1'b1;
        gnt_o[w_idx]  = 1'b1;
        gnt_idx_o     = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arb_mux_n.sv
// +----------------------------------------------------------------------+
// | arb_mux_n                                                            |
// | Registered N-channel arbitrating mux with RR/fixed priority + lock.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_mux_n
  import arb_mux_n_pkg::*;
#(
  parameter  int BUS_WIDTH = 32,
  parameter  int N_CH      = 4,
  parameter  int ARB_MODE  = ARB_RR,
  localparam int SEL_W     = $clog2(N_CH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  arb_mux_n_if.slave  bus
);

  localparam logic [SEL_W-1:0] C_LAST = SEL_W'(N_CH - 1);

  logic                 o_valid_q, o_valid_d;
  logic [BUS_WIDTH-1:0] o_data_q,  o_data_d;
  logic [SEL_W-1:0]     o_sel_q,   o_sel_d;
  logic [SEL_W-1:0]     ptr_q,     ptr_d;
  logic [0:0]           state_q,   state_d;
  logic [SEL_W-1:0]     lock_ch_q, lock_ch_d;

  logic                 w_load;
  logic                 w_accept;
  logic [N_CH-1:0]      w_lock_mask;
  logic [N_CH-1:0]      w_elig;
  logic [SEL_W-1:0]     w_ptr;
  logic [N_CH-1:0]      w_gnt;
  logic [SEL_W-1:0]     w_gnt_idx;
  logic [BUS_WIDTH-1:0] w_gnt_data;

  assign w_load = ~o_valid_q | bus.i_ready;

  always_comb begin
    w_lock_mask            = '0;
    w_lock_mask[lock_ch_q] = 1'b1;
  end

  // A held lock excludes every other channel even while the owner is idle
  assign w_elig = (state_q == ST_LOCKED) ? (bus.i_valid & w_lock_mask) : bus.i_valid;
  assign w_ptr  = (ARB_MODE == ARB_FIXED) ? '0 : ptr_q;

  arb_mux_n_rr_pick #(
    .N_CH (N_CH)
  ) u_pick (
    .req_i     (w_elig),
    .ptr_i     (w_ptr),
    .gnt_o     (w_gnt),
    .gnt_idx_o (w_gnt_idx)
  );

  assign w_accept    = w_load & (|w_gnt);
  assign bus.o_ready = {N_CH{w_load}} & w_gnt;

  // AND-OR mux keeps non-granted channels off the output path entirely
  always_comb begin
    w_gnt_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_gnt_data = w_gnt_data | (bus.i_data[k*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{w_gnt[k]}});
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_sel_d   = o_sel_q;
    ptr_d     = ptr_q;
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    if (w_accept) begin
      o_valid_d = 1'b1;
      o_data_d  = w_gnt_data;
      o_sel_d   = w_gnt_idx;
      if (ARB_MODE != ARB_FIXED) begin
        ptr_d = (w_gnt_idx == C_LAST) ? '0 : w_gnt_idx + SEL_W'(1);
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.i_lock[w_gnt_idx]) begin
            state_d   = ST_LOCKED;
            lock_ch_d = w_gnt_idx;
          end
        end
        default: begin
          if (!bus.i_lock[w_gnt_idx]) begin
            state_d = ST_IDLE;
          end
        end
      endcase
    end else if (w_load) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sel_q   <= '0;
      ptr_q     <= '0;
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_sel_q   <= o_sel_d;
      ptr_q     <= ptr_d;
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_sel   = o_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_arb_mux_n.sv
// +----------------------------------------------------------------------+
// | tb_arb_mux_n                                                         |
// | Drives RR and fixed-priority instances and checks against a model.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_arb_mux_n;

  localparam int N  = 4;
  localparam int BW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  valid = '0;
  logic [N-1:0]  lock  = '0;
  logic          ready = 1'b1;
  logic [BW-1:0] data [N];

  int total = 0;
  int bad   = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance
  bit            mv   [2];
  logic [BW-1:0] md   [2];
  int            ms   [2];
  int            mptr [2];
  bit            mlk  [2];
  int            mlc  [2];

  arb_mux_n_if #(.N_CH(N), .BUS_WIDTH(BW)) bus_rr ();
  arb_mux_n_if #(.N_CH(N), .BUS_WIDTH(BW)) bus_fx ();

  assign bus_rr.i_valid = valid;
  assign bus_rr.i_lock  = lock;
  assign bus_rr.i_ready = ready;
  assign bus_rr.i_data  = {data[3], data[2], data[1], data[0]};
  assign bus_fx.i_valid = valid;
  assign bus_fx.i_lock  = lock;
  assign bus_fx.i_ready = ready;
  assign bus_fx.i_data  = {data[3], data[2], data[1], data[0]};

  arb_mux_n #(.BUS_WIDTH(BW), .N_CH(N), .ARB_MODE(0)) u_rr (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_rr.slave)
  );

  arb_mux_n #(.BUS_WIDTH(BW), .N_CH(N), .ARB_MODE(1)) u_fx (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_fx.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: next-state from the arbitration rules, checked every cycle
  task automatic model_step(input int m);
    logic [N-1:0]  a_rdy;
    logic          a_v;
    logic [BW-1:0] a_d;
    int            a_s;
    bit            load;
    logic [N-1:0]  elig;
    logic [N-1:0]  e_rdy;
    int            start;
    int            g;
    if (m == 0) begin
      a_rdy = bus_rr.o_ready; a_v = bus_rr.o_valid; a_d = bus_rr.o_data; a_s = int'(bus_rr.o_sel);
    end else begin
      a_rdy = bus_fx.o_ready; a_v = bus_fx.o_valid; a_d = bus_fx.o_data; a_s = int'(bus_fx.o_sel);
    end
    if (rst) begin
      mv[m] = 0; md[m] = '0; ms[m] = 0; mptr[m] = 0; mlk[m] = 0; mlc[m] = 0;
    end
    load = !mv[m] || ready;
    elig = valid;
    if (mlk[m]) begin
      elig = '0;
      elig[mlc[m]] = valid[mlc[m]];
    end
    start = (m == 1) ? 0 : mptr[m];
    g = -1;
    for (int o = 0; o < N; o++) begin
      if (g < 0 && elig[(start + o) % N]) g = (start + o) % N;
    end
    e_rdy = '0;
    if (load && g >= 0) e_rdy[g] = 1'b1;
    chk($sformatf("m%0d o_ready", m), 32'(a_rdy), 32'(e_rdy));
    chk($sformatf("m%0d o_valid", m), 32'(a_v), 32'(mv[m]));
    chk($sformatf("m%0d o_data", m), a_d, md[m]);
    chk($sformatf("m%0d o_sel", m), 32'(a_s), 32'(ms[m]));
    if (!rst) begin
      if (load && g >= 0) begin
        md[m] = data[g]; ms[m] = g; mv[m] = 1; mptr[m] = (g + 1) % N;
        if (!mlk[m] && lock[g]) begin
          mlk[m] = 1; mlc[m] = g;
        end else if (mlk[m] && !lock[g]) begin
          mlk[m] = 0;
        end
      end else if (load) begin
        mv[m] = 0;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #4;
      model_step(0);
      model_step(1);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; lock = '0; ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) data[k] = 32'hD000_0000 | 32'(k);
    do_reset();

    // Round-robin rotation with all channels requesting
    valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s1 rr sel", 32'(bus_rr.o_sel), 32'(i % 4));
      chk("s1 fx sel", 32'(bus_fx.o_sel), 32'd0);
    end

    // Backpressure holds the register; release loads with no bubble
    do_reset();
    data[2] = 32'hA5A5A5A5; valid = 4'b0100;
    tick();
    chk("s2 first data", bus_rr.o_data, 32'hA5A5A5A5);
    chk("s2 first sel", 32'(bus_rr.o_sel), 32'd2);
    data[0] = 32'h0000_1234; valid = 4'b0001; ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s2 stall ready", 32'(bus_rr.o_ready), 32'd0);
      tick();
      chk("s2 stall data", bus_rr.o_data, 32'hA5A5A5A5);
    end
    ready = 1'b1;
    #1;
    chk("s2 release ready", 32'(bus_rr.o_ready), 32'b0001);
    tick();
    chk("s2 next data", bus_rr.o_data, 32'h0000_1234);
    chk("s2 next valid", 32'(bus_rr.o_valid), 32'd1);
    valid = '0;
    tick();
    chk("s2 drain valid", 32'(bus_rr.o_valid), 32'd0);
    chk("s2 drain hold", bus_rr.o_data, 32'h0000_1234);

    // Four-beat locked burst from ch1, then ch3 and ch0 in RR order
    do_reset();
    valid = 4'b0010; lock = 4'b0010;
    tick(); chk("s3 b1", 32'(bus_rr.o_sel), 32'd1);
    valid = 4'b1011;
    tick(); chk("s3 b2", 32'(bus_rr.o_sel), 32'd1);
    tick(); chk("s3 b3", 32'(bus_rr.o_sel), 32'd1);
    lock = 4'b0000;
    tick(); chk("s3 b4", 32'(bus_rr.o_sel), 32'd1);
    valid = 4'b1001;
    tick(); chk("s3 after1", 32'(bus_rr.o_sel), 32'd3);
    tick(); chk("s3 after2", 32'(bus_rr.o_sel), 32'd0);

    // Locked owner goes idle: others still wait
    do_reset();
    valid = 4'b0010; lock = 4'b0010;
    tick(); chk("s4 locked", 32'(bus_rr.o_sel), 32'd1);
    valid = 4'b0001;
    #1; chk("s4 blocked ready", 32'(bus_rr.o_ready), 32'd0);
    tick(); chk("s4 gap valid", 32'(bus_rr.o_valid), 32'd0);
    tick(); chk("s4 gap valid2", 32'(bus_fx.o_valid), 32'd0);
    valid = 4'b0011; lock = 4'b0000;
    tick(); chk("s4 resume", 32'(bus_rr.o_sel), 32'd1);
    tick(); chk("s4 then ch0", 32'(bus_rr.o_sel), 32'd0);

    // Fixed priority starves ch3 while ch1 requests
    do_reset();
    valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5 fx sel", 32'(bus_fx.o_sel), 32'd1);
      chk("s5 rr sel", 32'(bus_rr.o_sel), (i % 2 == 0) ? 32'd1 : 32'd3);
    end
    valid = 4'b1000;
    tick(); chk("s5 fx ch3", 32'(bus_fx.o_sel), 32'd3);

    // Asynchronous reset mid-burst
    do_reset();
    valid = 4'b0100; lock = 4'b0100;
    tick();
    valid = 4'b1111;
    tick(); chk("s6 pre valid", 32'(bus_rr.o_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("s6 rst valid", 32'(bus_rr.o_valid), 32'd0);
    chk("s6 rst sel", 32'(bus_rr.o_sel), 32'd0);
    tick();
    rst = 1'b0; lock = '0;
    tick(); chk("s6 after rr", 32'(bus_rr.o_sel), 32'd0);
    chk("s6 after fx", 32'(bus_fx.o_sel), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      tick();
      valid = 4'($urandom);
      lock  = 4'($urandom) & 4'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++) data[k] = $urandom;
      rst = ($urandom_range(0, 299) == 0);
    end
    tick();
    rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
